// File: rtl/ip_scc_sound_pkg.sv
// rtl/ip_scc_sound_pkg.sv - shared widths, constants and ramp state type for the SCC sound DAC
// Purpose: common definitions imported by ip_scc_sound_dac and ip_scc_dsm.
// Ports: none (package).
package ip_scc_sound_pkg;

  localparam int IN_W  = 11;
  localparam int OUT_W = 12;
  localparam int ACC_W = 13;

  localparam logic [11:0] PCM_MID = 12'h800;
  localparam int          SAT_MAX = 2047;
  localparam int          SAT_MIN = -2048;

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN
  } ramp_state_t;

endpackage

// File: rtl/ip_scc_dsm.sv
// rtl/ip_scc_dsm.sv - first-order delta-sigma modulator for the SCC audio pin
// Purpose: turns offset-binary PCM into a 1-bit stream whose density of ones
//   equals pcm_in/4096; runs every clk.
// Ports:
//   clk      in   system clock
//   n_reset  in   synchronous active-low reset
//   pcm_in   in   unsigned offset-binary PCM
//   dac_out  out  bit stream (carry of the accumulator add)
module ip_scc_dsm
  import ip_scc_sound_pkg::*;
(
  input  logic             clk,
  input  logic             n_reset,
  input  logic [OUT_W-1:0] pcm_in,
  output logic             dac_out
);

  logic [ACC_W-1:0] acc;

  // The top bit of acc holds the carry of the previous add; only the low
  // bits recirculate, so acc[ACC_W-1] is the registered output bit.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      acc <= '0;
    end else begin
      acc <= {1'b0, acc[ACC_W-2:0]} + {1'b0, pcm_in};
    end
  end

  assign dac_out = acc[ACC_W-1];

endmodule

// File: rtl/ip_scc_sound_dac.sv
// rtl/ip_scc_sound_dac.sv - ramped-volume SCC sound stage with saturation and delta-sigma output
// Purpose: scales the SCC sample by a ramped gain, saturates to OUT_W bits,
//   offsets to unsigned PCM and drives a delta-sigma audio bit.
// Optional: define SCC_SOUND_DCCUT_EN to insert a one-pole DC blocker after
//   saturation (adds one cycle of latency).
// Ports:
//   clk          in   system clock
//   n_reset      in   synchronous active-low reset
//   mclk_pcen_n  in   sample enable, active-low
//   sound_in     in   signed sample from SCC
//   volume       in   target gain 0..15 (4 = unity)
//   mute         in   forces target gain to 0, ramped
//   pcm_out      out  offset-binary PCM
//   clip         out  last sample saturated
//   ramp_busy    out  current gain differs from target
//   dac_out      out  delta-sigma bit stream
module ip_scc_sound_dac #(
  parameter int IN_W       = ip_scc_sound_pkg::IN_W,
  parameter int OUT_W      = ip_scc_sound_pkg::OUT_W,
  parameter int GAIN_SHIFT = 2
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   mclk_pcen_n,
  input  logic signed [IN_W-1:0] sound_in,
  input  logic [3:0]             volume,
  input  logic                   mute,
  output logic [OUT_W-1:0]       pcm_out,
  output logic                   clip,
  output logic                   ramp_busy,
  output logic                   dac_out
);

  import ip_scc_sound_pkg::*;

  localparam int P_W = IN_W + 4;

  function automatic logic [OUT_W-1:0] to_offset(input logic signed [OUT_W-1:0] x);
    return {~x[OUT_W-1], x[OUT_W-2:0]};
  endfunction

  logic        se;
  logic [3:0]  tgt;
  ramp_state_t state, state_nxt;
  logic [3:0]  cur_gain, gain_nxt;

  assign se  = !mclk_pcen_n;
  assign tgt = mute ? 4'd0 : volume;

  // Direction is re-derived from the comparison on every sample, so a target
  // change mid-ramp turns the ramp around without overshooting.
  always_comb begin
    state_nxt = state;
    gain_nxt  = cur_gain;
    if (se) begin
      if (cur_gain < tgt) begin
        gain_nxt  = cur_gain + 4'd1;
        state_nxt = (cur_gain + 4'd1 == tgt) ? IDLE : UP;
      end else if (cur_gain > tgt) begin
        gain_nxt  = cur_gain - 4'd1;
        state_nxt = (cur_gain - 4'd1 == tgt) ? IDLE : DOWN;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  logic signed [IN_W-1:0] s0;
  logic [3:0]             g0;
  logic                   v0, v1;
  logic signed [P_W-1:0]  p;

  // g0 captures the gain in force before this sample's ramp step.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state     <= IDLE;
      cur_gain  <= '0;
      ramp_busy <= 1'b0;
      s0        <= '0;
      g0        <= '0;
      v0        <= 1'b0;
      v1        <= 1'b0;
      p         <= '0;
    end else begin
      state     <= state_nxt;
      cur_gain  <= gain_nxt;
      ramp_busy <= (cur_gain != tgt);
      v0        <= se;
      v1        <= v0;
      if (se) begin
        s0 <= sound_in;
        g0 <= cur_gain;
      end
      if (v0) begin
        p <= P_W'(s0) * P_W'($signed({1'b0, g0}));
      end
    end
  end

  logic signed [P_W-1:0]   q_full;
  logic                    sat_hi, sat_lo;
  logic signed [OUT_W-1:0] q_sat;

  assign q_full = p >>> GAIN_SHIFT;
  assign sat_hi = q_full > P_W'(SAT_MAX);
  assign sat_lo = q_full < P_W'(SAT_MIN);
  assign q_sat  = sat_hi ? OUT_W'(SAT_MAX) :
                  sat_lo ? OUT_W'(SAT_MIN) : q_full[OUT_W-1:0];

`ifdef SCC_SOUND_DCCUT_EN
  localparam int Y_W = OUT_W + 3;

  logic                    v2, clip2;
  logic signed [OUT_W-1:0] x_cur, x_prev, y_prev, y_sat;
  logic signed [Y_W-1:0]   y_full;
  logic                    y_hi, y_lo;

  // y = x - x_prev + y_prev - y_prev/256: pole just inside z=1.
  assign y_full = Y_W'(x_cur) - Y_W'(x_prev) + Y_W'(y_prev) - Y_W'(y_prev >>> 8);
  assign y_hi   = y_full > Y_W'(SAT_MAX);
  assign y_lo   = y_full < Y_W'(SAT_MIN);
  assign y_sat  = y_hi ? OUT_W'(SAT_MAX) :
                  y_lo ? OUT_W'(SAT_MIN) : y_full[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      v2      <= 1'b0;
      clip2   <= 1'b0;
      x_cur   <= '0;
      x_prev  <= '0;
      y_prev  <= '0;
      pcm_out <= PCM_MID;
      clip    <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        x_cur <= q_sat;
        clip2 <= sat_hi | sat_lo;
      end
      if (v2) begin
        x_prev  <= x_cur;
        y_prev  <= y_sat;
        pcm_out <= to_offset(y_sat);
        clip    <= clip2 | y_hi | y_lo;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      pcm_out <= PCM_MID;
      clip    <= 1'b0;
    end else if (v1) begin
      pcm_out <= to_offset(q_sat);
      clip    <= sat_hi | sat_lo;
    end
  end
`endif

  ip_scc_dsm u_dsm (
    .clk     (clk),
    .n_reset (n_reset),
    .pcm_in  (pcm_out),
    .dac_out (dac_out)
  );

endmodule

// File: tb/tb_ip_scc_sound_dac.sv
// tb/tb_ip_scc_sound_dac.sv - self-checking bench for ip_scc_sound_dac
module tb_ip_scc_sound_dac;

  logic               clk         = 1'b0;
  logic               n_reset     = 1'b0;
  logic               mclk_pcen_n = 1'b1;
  logic signed [10:0] sound_in    = '0;
  logic [3:0]         volume      = 4'd0;
  logic               mute        = 1'b0;
  logic [11:0]        pcm_out;
  logic               clip;
  logic               ramp_busy;
  logic               dac_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ip_scc_sound_dac dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .mclk_pcen_n (mclk_pcen_n),
    .sound_in    (sound_in),
    .volume      (volume),
    .mute        (mute),
    .pcm_out     (pcm_out),
    .clip        (clip),
    .ramp_busy   (ramp_busy),
    .dac_out     (dac_out)
  );

  typedef struct {
    logic [3:0]         vol;
    logic signed [10:0] snd;
    logic [11:0]        pcm;
    logic               clp;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic signed [10:0] snd);
    sound_in    = snd;
    mclk_pcen_n = 1'b0;
    tick();
    mclk_pcen_n = 1'b1;
  endtask

  task automatic sample(input logic signed [10:0] snd);
    pulse(snd);
    tick();
    tick();
  endtask

  task automatic settle(input logic [3:0] vol, input logic m);
    volume = vol;
    mute   = m;
    repeat (16) begin
      pulse(11'sd0);
      tick(); tick(); tick();
    end
  endtask

  task automatic count_ones(output int n);
    n = 0;
    repeat (4096) begin
      tick();
      n += int'(dac_out);
    end
  endtask

  initial begin
    int ones;

    vecs[0]  = '{4'd4,  11'sd100,   12'h864, 1'b0};
    vecs[1]  = '{4'd15, 11'sd1023,  12'hFFF, 1'b1};
    vecs[2]  = '{4'd15, -11'sd1024, 12'h000, 1'b1};
    vecs[3]  = '{4'd8,  -11'sd300,  12'h5A8, 1'b0};
    vecs[4]  = '{4'd1,  -11'sd3,    12'h7FF, 1'b0};
    vecs[5]  = '{4'd4,  -11'sd1024, 12'h400, 1'b0};
    vecs[6]  = '{4'd4,  11'sd1023,  12'hBFF, 1'b0};
    vecs[7]  = '{4'd9,  11'sd910,   12'hFFF, 1'b0};
    vecs[8]  = '{4'd9,  -11'sd910,  12'h000, 1'b0};
    vecs[9]  = '{4'd9,  -11'sd911,  12'h000, 1'b1};
    vecs[10] = '{4'd0,  11'sd1023,  12'h800, 1'b0};
    vecs[11] = '{4'd12, 11'sd683,   12'hFFF, 1'b1};
    vecs[12] = '{4'd3,  11'sd5,     12'h803, 1'b0};

    // Reset with a concurrent sample enable
    n_reset     = 1'b0;
    mclk_pcen_n = 1'b0;
    sound_in    = 11'sd300;
    volume      = 4'd4;
    repeat (3) tick();
    check("rst_pcm", pcm_out, 12'h800);
    check("rst_clip", clip, 1'b0);
    check("rst_busy", ramp_busy, 1'b0);
    check("rst_dac", dac_out, 1'b0);
    n_reset     = 1'b1;
    mclk_pcen_n = 1'b1;
    sound_in    = 11'sd0;

    // Ramp 0 -> 4 over four samples
    for (int k = 1; k <= 4; k++) begin
      pulse(11'sd0);
      tick(); tick(); tick();
      check($sformatf("ramp_busy_%0d", k), ramp_busy, (k < 4) ? 1'b1 : 1'b0);
    end
    check("ramp_pcm", pcm_out, 12'h800);
    count_ones(ones);
    check("dsm_800", ones, 2048);

    // Exact latency at unity gain
    sound_in    = 11'sd100;
    mclk_pcen_n = 1'b0;
    tick();
    mclk_pcen_n = 1'b1;
    check("lat_n", pcm_out, 12'h800);
    tick();
    check("lat_n1", pcm_out, 12'h800);
    tick();
    check("lat_n2", pcm_out, 12'h864);
    check("lat_clip", clip, 1'b0);

    // Back-to-back samples are fully pipelined
    sound_in    = -11'sd200;
    mclk_pcen_n = 1'b0;
    tick();
    sound_in    = 11'sd100;
    tick();
    mclk_pcen_n = 1'b1;
    tick();
    check("b2b_first", pcm_out, 12'h738);
    tick();
    check("b2b_second", pcm_out, 12'h864);

    // Gain/saturation table
    for (int i = 0; i < 13; i++) begin
      settle(vecs[i].vol, 1'b0);
      sample(vecs[i].snd);
      check($sformatf("vec%0d_pcm", i), pcm_out, vecs[i].pcm);
      check($sformatf("vec%0d_clip", i), clip, vecs[i].clp);
    end

    // Clip holds until the next sample result, which clears it
    settle(4'd15, 1'b0);
    sample(11'sd1023);
    check("clip_set", clip, 1'b1);
    tick(); tick();
    check("clip_hold", clip, 1'b1);
    sample(11'sd0);
    check("clip_clear", clip, 1'b0);
    check("clip_clear_pcm", pcm_out, 12'h800);

    // Mute ramps 10 -> 0 over ten samples
    settle(4'd10, 1'b0);
    mute = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      pulse(11'sd0);
      tick(); tick(); tick();
      if (k >= 9) check($sformatf("mute_busy_%0d", k), ramp_busy, (k < 10) ? 1'b1 : 1'b0);
    end
    sample(11'sd1000);
    check("mute_pcm", pcm_out, 12'h800);

    // Reversal mid-ramp: 10 -> 6 muted, then volume 12
    settle(4'd10, 1'b0);
    mute = 1'b1;
    repeat (4) begin
      pulse(11'sd0);
      tick(); tick(); tick();
    end
    mute   = 1'b0;
    volume = 4'd12;
    sample(11'sd400);
    check("rev_gain6", pcm_out, 12'hA58);
    for (int k = 1; k <= 5; k++) begin
      tick();
      pulse(11'sd0);
      tick(); tick(); tick();
      check($sformatf("rev_busy_%0d", k), ramp_busy, (k < 5) ? 1'b1 : 1'b0);
    end
    sample(11'sd400);
    check("rev_gain12", pcm_out, 12'hCB0);

    // Delta-sigma density at quarter and three-quarter scale
    settle(4'd4, 1'b0);
    sample(-11'sd1024);
    check("dsm_400_pcm", pcm_out, 12'h400);
    count_ones(ones);
    check("dsm_400", ones, 1024);
    settle(4'd8, 1'b0);
    sample(11'sd512);
    check("dsm_c00_pcm", pcm_out, 12'hC00);
    count_ones(ones);
    check("dsm_c00", ones, 3072);

    // Reset during an upward ramp
    settle(4'd0, 1'b0);
    volume = 4'd8;
    pulse(11'sd0); tick(); tick(); tick();
    pulse(11'sd0); tick(); tick(); tick();
    sample(11'sd500);
    check("pre_rst_pcm", pcm_out, 12'h8FA);
    n_reset     = 1'b0;
    mclk_pcen_n = 1'b0;
    sound_in    = 11'sd500;
    tick();
    check("mid_rst_pcm", pcm_out, 12'h800);
    check("mid_rst_clip", clip, 1'b0);
    check("mid_rst_busy", ramp_busy, 1'b0);
    check("mid_rst_dac", dac_out, 1'b0);
    n_reset     = 1'b1;
    mclk_pcen_n = 1'b1;
    tick();
    check("post_rst_busy", ramp_busy, 1'b1);
    sample(11'sd400);
    check("post_rst_gain0", pcm_out, 12'h800);
    sample(11'sd400);
    check("post_rst_gain1", pcm_out, 12'h864);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ip_scc_sound_dac.md
Name: ip_scc_sound_dac

Overview:
Downstream audio stage for the IKA-SCC wrapper. It consumes the 11-bit SCC digital sound output and applies a zipper-free ramped volume with mute. The scaled value is saturated to 12 bits and converted to a 1-bit first-order delta-sigma stream that drives the cartridge audio pin through an RC filter.
Runs entirely in the clk domain and shares the phiM clock-enable (mclk_pcen_n) with the SCC wrapper.

Parameters:
IN_W, 11, width of signed input sample (SCC sound_out)
OUT_W, 12, width of saturated signed PCM and of delta-sigma accumulator data path
GAIN_SHIFT, 2, arithmetic right shift applied after gain multiply (gain 4 = unity)

Ports:
clk  in  1  system clock
n_reset  in  1  reset, synchronous, active-low
mclk_pcen_n  in  1  phiM positive-edge clock enable, active-low; one sample per assertion
sound_in  in  IN_W  signed two's-complement sample from SCC
volume  in  4  target gain 0..15
mute  in  1  1 = target gain forced to 0 (ramped, not instant)
pcm_out  out  OUT_W  unsigned offset-binary PCM (signed result + 2048)
clip  out  1  1 = last sample saturated; held until next sample result
ramp_busy  out  1  1 = current gain != effective target
dac_out  out  1  delta-sigma bit stream, updated every clk

Behaviour:
- Reset (n_reset=0 at clk edge): pcm_out=12'h800, clip=0, ramp_busy=0, dac_out=0, accumulator=0, cur_gain=0, pipeline regs=0, ramp state IDLE. Reset overrides a concurrent sample enable.
- Sample enable se = !mclk_pcen_n. Stage0: on se, latch sound_in into s0. Stage1 (next clk): p = s0 * cur_gain, 15-bit signed, gain zero-extended. Stage2 (next clk): q = p >>> GAIN_SHIFT, saturated to [-2048, 2047]; clip = (saturation occurred); pcm_out = q + 2048 (MSB invert).
- Latency: se at cycle N -> pcm_out/clip valid at N+2. Stages advance on every clk; a new se on two consecutive cycles is legal and fully pipelined.
- Effective target: tgt = mute ? 0 : volume.
- Ramp FSM, evaluated only on se, using cur_gain before the update; stage1 of that sample uses the old gain.
  - IDLE: if cur_gain < tgt -> UP; if cur_gain > tgt -> DOWN.
  - UP: cur_gain += 1; when the new value == tgt -> IDLE.
  - DOWN: cur_gain -= 1; when the new value == tgt -> IDLE.
  - If tgt changes mid-ramp, direction is re-evaluated at the next se. UP with cur_gain > tgt switches to DOWN without stepping past tgt.
  - Step is exactly 1 per sample. No overflow: cur_gain is bounded 0..15.
  - ramp_busy = (cur_gain != tgt), registered, updated every clk.
- Delta-sigma (every clk, independent of se): acc is 13 bits; acc <= {1'b0, acc[11:0]} + pcm_out; dac_out <= carry out of that add.
  - pcm_out=0 gives all zeros; pcm_out=4095 gives 4095/4096 ones.
  - Long-run density of ones = pcm_out/4096.
- Mid-operation reset clears everything as in the reset list above. The ramp restarts from gain 0 toward tgt.

Optional Feature:
SCC_SOUND_DCCUT_EN.
- Defined: a one-pole DC blocker is inserted between stage2 saturation and the offset step: y = x - x_prev + y_prev - (y_prev >>> 8). It updates one cycle after the stage2 result, on the registered se pipeline flag. y is saturated to 12 bits, and clip is ORed with this second saturation. Latency becomes N+3. x_prev and y_prev reset to 0.
- Undefined: no filter, latency N+2, identical to the Behaviour section.

Decomposition:
- Package ip_scc_sound_pkg holds:
  - width constants IN_W, OUT_W, ACC_W=13
  - PCM_MID=12'h800, SAT_MAX=2047, SAT_MIN=-2048
  - ramp state enum {IDLE, UP, DOWN}
- One sub-module, ip_scc_dsm: first-order delta-sigma modulator (clk, n_reset, pcm_in[11:0], dac_out). Gain, ramp and saturation logic stay in the top module.

Test Plan:
- Reset release with volume=4, mute=0, sound_in=0, se every 4 clk: cur_gain steps 0->4 over 4 se pulses with ramp_busy=1 during the ramp and 0 after; pcm_out=12'h800; dac_out density 50%.
- Gain 4, sound_in=11'sd100, single se at cycle N: pcm_out=12'h864 at N+2 exactly, clip=0; unchanged at N+1.
- Gain 15, sound_in=1023 -> pcm_out=12'hFFF, clip=1. Gain 15, sound_in=-1024 -> pcm_out=12'h000, clip=1. Next sample of 0 clears clip.
- From gain 10 at steady state, assert mute: 10 se pulses step the gain down to 0, then ramp_busy=0 and pcm_out=12'h800. Raise volume to 12 mid-ramp at gain 6: ramp reverses and reaches 12 after 6 more se.
- Hold pcm_out=12'h400 (gain 4, sound_in=-1024) for 4096 clk: exactly 1024 ones on dac_out. Repeat for 12'hC00 and expect 3072 ones.
- Assert n_reset for 1 clk during UP ramp with se concurrent: all outputs return to reset values that cycle; the ramp restarts from 0. With SCC_SOUND_DCCUT_EN, a constant input of 500 decays toward pcm_out=12'h800 over about 2000 samples.
